// File: rtl/rev_gate_seq.sv
// Reversible WIDTH-bit register with CNOT/Toffoli/NOT fan-out gates.
// Every accepted gate goes onto a LIFO history so it can be undone, newest first.
module rev_gate_seq #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 op_mode,
  input  logic [IW-1:0]              op_ctrl_a,
  input  logic [IW-1:0]              op_ctrl_b,
  input  logic [WIDTH-1:0]           op_mask,
  input  logic                       undo_valid,
  output logic                       undo_ready,
  output logic [WIDTH-1:0]           state_q,
  output logic [$clog2(DEPTH+1)-1:0] hist_count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    M_CNOT = 2'b00,
    M_TOF  = 2'b01,
    M_NOT  = 2'b10,
    M_ILL  = 2'b11
  } mode_e;

  typedef struct packed {
    mode_e           mode;
    logic [IW-1:0]   a;
    logic [IW-1:0]   b;
    logic [WIDTH-1:0] mask;
  } hent_t;

  hent_t hist [DEPTH];

  // Controls are stripped from the target set, so applying a gate twice restores the state.
  function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] s, input hent_t e);
    logic [WIDTH-1:0] ma, mb, t;
    logic             c;
    ma = WIDTH'(1) << e.a;
    mb = WIDTH'(1) << e.b;
    t  = '0;
    c  = 1'b0;
    case (e.mode)
      M_CNOT: begin t = e.mask & ~ma;       c = |(s & ma);                end
      M_TOF:  begin t = e.mask & ~ma & ~mb; c = (|(s & ma)) & (|(s & mb)); end
      M_NOT:  begin t = e.mask;             c = 1'b1;                     end
      default: ;
    endcase
    return c ? (s ^ t) : s;
  endfunction

  function automatic logic idx_bad(input logic [IW-1:0] i);
    return {1'b0, i} >= (IW+1)'(WIDTH);
  endfunction

  logic             full, empty;
  logic             do_load, do_undo, do_op;
  logic             op_ill, push;
  hent_t            op_ent, top_ent;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [WIDTH-1:0] state_d;
  logic [CW-1:0]    cnt_d;
  logic             err_d;

  assign full  = (hist_count == CW'(DEPTH));
  assign empty = (hist_count == '0);

  // Readiness reflects only occupancy and the load > undo > op priority.
  assign undo_ready = !empty && !load_valid;
  assign op_ready   = !full && !load_valid && !(undo_valid && !empty);

  assign do_load = load_valid;
  assign do_undo = undo_valid && undo_ready;
  assign do_op   = op_valid && op_ready;

  assign op_ent = '{mode: mode_e'(op_mode), a: op_ctrl_a, b: op_ctrl_b, mask: op_mask};

  // Only the indices a mode actually uses are range-checked.
  always_comb begin
    op_ill = 1'b0;
    case (op_ent.mode)
      M_CNOT:  op_ill = idx_bad(op_ctrl_a);
      M_TOF:   op_ill = idx_bad(op_ctrl_a) || idx_bad(op_ctrl_b) || (op_ctrl_a == op_ctrl_b);
      M_NOT:   op_ill = 1'b0;
      default: op_ill = 1'b1;
    endcase
  end

  assign push_idx = AW'(hist_count);
  assign pop_idx  = AW'(hist_count - CW'(1));
  assign top_ent  = hist[pop_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = hist_count;
    err_d   = err;
    push    = 1'b0;
    if (do_load) begin
      state_d = load_data;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (do_undo) begin
      state_d = gate(state_q, top_ent);
      cnt_d   = hist_count - CW'(1);
    end else if (do_op) begin
      if (op_ill) begin
        err_d = 1'b1;
      end else begin
        state_d = gate(state_q, op_ent);
        cnt_d   = hist_count + CW'(1);
        push    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= '0;
      hist_count <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_count <= cnt_d;
      err        <= err_d;
    end
  end

  // Entries above hist_count are dead, so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) hist[push_idx] <= op_ent;
  end

endmodule

// File: tb/tb_rev_gate_seq.sv
// Scoreboard bench for rev_gate_seq: directed vectors push expected results,
// a monitor branch pops and compares on every accepted request.
module tb_rev_gate_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [4:0] load_data = '0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_mode = '0;
  logic [2:0] op_ctrl_a = '0;
  logic [2:0] op_ctrl_b = '0;
  logic [4:0] op_mask = '0;
  logic       undo_valid = 1'b0;
  logic       undo_ready;
  logic [4:0] state_q;
  logic [3:0] hist_count;
  logic       err;

  rev_gate_seq #(.WIDTH(5), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode),
    .op_ctrl_a(op_ctrl_a), .op_ctrl_b(op_ctrl_b), .op_mask(op_mask),
    .undo_valid(undo_valid), .undo_ready(undo_ready),
    .state_q(state_q), .hist_count(hist_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] s;
    logic [3:0] c;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [4:0] ld, input logic uv, input logic ov,
                       input logic [1:0] m, input logic [2:0] a, input logic [2:0] b,
                       input logic [4:0] mk);
    @(negedge clk);
    load_valid = lv; load_data = ld; undo_valid = uv; op_valid = ov;
    op_mode = m; op_ctrl_a = a; op_ctrl_b = b; op_mask = mk;
  endtask

  task automatic expect_r(input string tag, input logic [4:0] s, input logic [3:0] c, input logic e);
    exp_t x;
    x.tag = tag; x.s = s; x.c = c; x.e = e;
    q.push_back(x);
  endtask

  task automatic do_load(input string tag, input logic [4:0] d);
    drive(1, d, 0, 0, 2'b00, 0, 0, 0);
    expect_r(tag, d, 0, 0);
    @(posedge clk);
  endtask

  task automatic do_op(input string tag, input logic [1:0] m, input logic [2:0] a,
                       input logic [2:0] b, input logic [4:0] mk,
                       input logic [4:0] es, input logic [3:0] ec, input logic ee);
    drive(0, 0, 0, 1, m, a, b, mk);
    expect_r(tag, es, ec, ee);
    @(posedge clk);
  endtask

  task automatic do_undo(input string tag, input logic [4:0] es, input logic [3:0] ec, input logic ee);
    drive(0, 0, 1, 0, 2'b00, 0, 0, 0);
    expect_r(tag, es, ec, ee);
    @(posedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic stimulus();
    logic [4:0] nots [8];
    logic [4:0] st_after [8];
    logic [4:0] undo_st [8];
    nots     = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010, 5'b00100};
    st_after = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11110, 5'b11100, 5'b11000};
    undo_st  = '{5'b11100, 5'b11110, 5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};

    // power-on reset
    #2 rst = 1'b1;
    #1;
    chk("por_state", state_q, 5'b00000);
    chk("por_cnt", hist_count, 0);
    chk("por_err", err, 0);
    chk("por_op_ready", op_ready, 1);
    chk("por_undo_ready", undo_ready, 0);
    @(negedge clk) rst = 1'b0;

    // mid-run reset from 10101 / count 3
    do_load("rs_load", 5'b00000);
    do_op("rs_n0", 2'b10, 0, 0, 5'b00001, 5'b00001, 1, 0);
    do_op("rs_n2", 2'b10, 0, 0, 5'b00100, 5'b00101, 2, 0);
    do_op("rs_n4", 2'b10, 0, 0, 5'b10000, 5'b10101, 3, 0);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_state", state_q, 5'b00000);
    chk("rst_cnt", hist_count, 0);
    chk("rst_err", err, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_undo_ready", undo_ready, 0);
    @(negedge clk) rst = 1'b0;

    // CNOT fan-out and undo
    do_load("cn_load", 5'b00001);
    do_op("cn_op", 2'b00, 0, 0, 5'b11111, 5'b11111, 1, 0);
    do_undo("cn_undo", 5'b00001, 0, 0);

    // Toffoli, condition true then false
    do_load("tf_load1", 5'b00011);
    do_op("tf_true", 2'b01, 0, 1, 5'b11100, 5'b11111, 1, 0);
    do_load("tf_load2", 5'b00001);
    do_op("tf_false", 2'b01, 0, 1, 5'b11100, 5'b00001, 1, 0);

    // fill the history
    do_load("fl_load", 5'b00000);
    for (int i = 0; i < 8; i++)
      do_op($sformatf("fl_not%0d", i), 2'b10, 0, 0, nots[i], st_after[i], 4'(i + 1), 0);
    idle();
    #1;
    chk("full_op_ready", op_ready, 0);
    chk("full_undo_ready", undo_ready, 1);
    drive(0, 0, 0, 1, 2'b10, 0, 0, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_state", state_q, 5'b11000);
      chk("hold_cnt", hist_count, 8);
      chk("hold_op_ready", op_ready, 0);
    end
    for (int i = 0; i < 8; i++)
      do_undo($sformatf("em_undo%0d", i), undo_st[i], 4'(7 - i), 0);
    idle();
    #1;
    chk("empty_undo_ready", undo_ready, 0);
    chk("empty_state", state_q, 5'b00000);

    // three-way collision: load wins
    drive(1, 5'b01010, 1, 1, 2'b10, 0, 0, 5'b11111);
    expect_r("col3", 5'b01010, 0, 0);
    #1;
    chk("col3_op_ready", op_ready, 0);
    chk("col3_undo_ready", undo_ready, 0);
    @(posedge clk);
    do_op("col_n0", 2'b10, 0, 0, 5'b00001, 5'b01011, 1, 0);
    do_op("col_n2", 2'b10, 0, 0, 5'b00100, 5'b01111, 2, 0);
    // undo beats op, op lands next cycle
    drive(0, 0, 1, 1, 2'b10, 0, 0, 5'b10000);
    expect_r("col_undo", 5'b01011, 1, 0);
    #1;
    chk("col_op_ready", op_ready, 0);
    chk("col_undo_ready", undo_ready, 1);
    @(posedge clk);
    @(negedge clk);
    undo_valid = 1'b0;
    expect_r("col_op", 5'b11011, 2, 0);
    #1;
    chk("col_op_ready2", op_ready, 1);
    @(posedge clk);

    // illegal requests
    do_load("il_load", 5'b00110);
    do_op("il_cnot_f", 2'b00, 0, 0, 5'b11111, 5'b00110, 1, 0);
    do_op("il_mode3", 2'b11, 0, 1, 5'b11111, 5'b00110, 1, 1);
    do_op("il_idx7", 2'b00, 7, 0, 5'b11111, 5'b00110, 1, 1);
    do_op("il_tofab", 2'b01, 2, 2, 5'b11111, 5'b00110, 1, 1);
    do_load("il_clear", 5'b00000);
    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic monitor();
    exp_t x;
    forever begin
      @(posedge clk);
      if (!rst && (load_valid || (undo_valid && undo_ready) || (op_valid && op_ready))) begin
        #1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_accept: got state %0h, expected no accept", state_q);
        end else begin
          x = q.pop_front();
          chk({x.tag, "_state"}, state_q, x.s);
          chk({x.tag, "_cnt"}, hist_count, x.c);
          chk({x.tag, "_err"}, err, x.e);
        end
      end
    end
  endtask

  initial begin
    fork
      stimulus();
      monitor();
      begin
        #100000;
        checks++;
        errors++;
        $display("FAIL timeout: got no completion, expected end of stimulus");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
